// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dram_pkg
//  Description : Shared definitions for the DRAM controller: the controller
//                state encoding and the default timing constants.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package dram_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ROW       = 4'd1,
    S_RAS       = 4'd2,
    S_COL       = 4'd3,
    S_CAS       = 4'd4,
    S_ACK       = 4'd5,
    S_REF_CAS   = 4'd6,
    S_REF_RAS   = 4'd7,
    S_PRECHARGE = 4'd8
  } dram_state_t;

  localparam int c_DEF_MA_W           = 11;
  localparam int c_DEF_T_RCD          = 1;
  localparam int c_DEF_T_CAS          = 2;
  localparam int c_DEF_T_RP           = 2;
  localparam int c_DEF_T_REF_RAS      = 3;
  localparam int c_DEF_REFRESH_CYCLES = 780;

  // Width of the shared phase counter; all timing parameters must fit.
  localparam int c_CNT_W = 8;

endpackage : dram_pkg
`default_nettype wire

// File: rtl/dram_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dram_refresh_timer
//  Description : Free-running refresh interval counter. Counts
//                0..REFRESH_CYCLES-1 and wraps; each wrap raises a pending
//                flag that the controller clears when it starts a refresh.
//                A wrap while the flag is already set is dropped (no backlog).
//  Ports       : clk           - system clock
//                rst           - synchronous active-high reset
//                i_clear       - controller is entering the refresh sequence
//                o_ref_pending - a refresh is owed
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_refresh_timer #(
  parameter int REFRESH_CYCLES = 780
)(
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_ref_pending
);

  localparam int c_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [c_W-1:0] c_LAST = c_W'(REFRESH_CYCLES - 1);

  logic [c_W-1:0] r_count;
  logic           r_pending;
  logic           w_wrap;

  assign w_wrap        = (r_count == c_LAST);
  assign o_ref_pending = r_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_count <= w_wrap ? '0 : r_count + 1'b1;
      // Clear has priority: the flag is still set at that edge, so a
      // coincident wrap counts as one that arrived while pending.
      if (i_clear)
        r_pending <= 1'b0;
      else if (w_wrap)
        r_pending <= 1'b1;
    end
  end

endmodule : dram_refresh_timer
`default_nettype wire

// File: rtl/dram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dram_controller
//  Description : CPU-to-DRAM responder for one 16-bit bank. Converts the
//                synchronised DRAM select / AS_n / data strobes into RAS/CAS
//                timing with a multiplexed row/column address and WE_n,
//                returns DTACK, and inserts CAS-before-RAS refresh.
//  Option      : DRAM_REFCNT_EN adds the 16-bit o_ref_count output.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_dram_n, i_as_n  - decoder select and address strobe
//                i_uds_n, i_lds_n  - upper/lower data strobes
//                i_rw              - 1 = read, 0 = write
//                i_addr            - CPU address bits [2*MA_W:1]
//                o_ma              - multiplexed DRAM address
//                o_ras_n, o_casu_n, o_casl_n, o_we_n - DRAM strobes
//                o_dtack_dram_n    - transfer acknowledge
//                o_ref_count       - completed refreshes (option only)
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_controller
  import dram_pkg::*;
#(
  parameter int MA_W           = c_DEF_MA_W,
  parameter int T_RCD          = c_DEF_T_RCD,
  parameter int T_CAS          = c_DEF_T_CAS,
  parameter int T_RP           = c_DEF_T_RP,
  parameter int T_REF_RAS      = c_DEF_T_REF_RAS,
  parameter int REFRESH_CYCLES = c_DEF_REFRESH_CYCLES
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_dram_n,
  input  logic              i_as_n,
  input  logic              i_uds_n,
  input  logic              i_lds_n,
  input  logic              i_rw,
  input  logic [2*MA_W-1:0] i_addr,
  output logic [MA_W-1:0]   o_ma,
  output logic              o_ras_n,
  output logic              o_casu_n,
  output logic              o_casl_n,
  output logic              o_we_n,
  output logic              o_dtack_dram_n
`ifdef DRAM_REFCNT_EN
  ,
  output logic [15:0]       o_ref_count
`endif
);

  localparam logic [c_CNT_W-1:0] c_LD_RCD = c_CNT_W'(T_RCD - 1);
  localparam logic [c_CNT_W-1:0] c_LD_CAS = c_CNT_W'(T_CAS - 1);
  localparam logic [c_CNT_W-1:0] c_LD_RP  = c_CNT_W'(T_RP - 1);
  localparam logic [c_CNT_W-1:0] c_LD_REF = c_CNT_W'(T_REF_RAS - 1);

  // ---------------- input synchronisers ----------------
  // Bit order: {dram_n, as_n, uds_n, lds_n, rw}; reset to the idle level.
  logic [4:0] r_sync1, r_sync2;
  logic       w_s_as_n, w_s_uds_n, w_s_lds_n, w_s_rw, w_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 5'b11111;
      r_sync2 <= 5'b11111;
    end else begin
      r_sync1 <= {i_dram_n, i_as_n, i_uds_n, i_lds_n, i_rw};
      r_sync2 <= r_sync1;
    end
  end

  assign w_s_as_n  = r_sync2[3];
  assign w_s_uds_n = r_sync2[2];
  assign w_s_lds_n = r_sync2[1];
  assign w_s_rw    = r_sync2[0];
  assign w_req     = ~r_sync2[4] & ~w_s_as_n & (~w_s_uds_n | ~w_s_lds_n);

  // ---------------- refresh timer ----------------
  logic w_ref_pending, w_ref_clear;

  dram_refresh_timer #(
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (w_ref_clear),
    .o_ref_pending (w_ref_pending)
  );

  // ---------------- FSM state and registered outputs ----------------
  dram_state_t        r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [MA_W-1:0]    r_ma, w_ma_nxt;
  logic               r_ras_n, w_ras_n_nxt;
  logic               r_casu_n, w_casu_n_nxt;
  logic               r_casl_n, w_casl_n_nxt;
  logic               r_we_n, w_we_n_nxt;
  logic               r_dtack_n, w_dtack_n_nxt;
  logic               w_to_pre, w_idle_decide;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ma      <= '0;
      r_ras_n   <= 1'b1;
      r_casu_n  <= 1'b1;
      r_casl_n  <= 1'b1;
      r_we_n    <= 1'b1;
      r_dtack_n <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ma      <= w_ma_nxt;
      r_ras_n   <= w_ras_n_nxt;
      r_casu_n  <= w_casu_n_nxt;
      r_casl_n  <= w_casl_n_nxt;
      r_we_n    <= w_we_n_nxt;
      r_dtack_n <= w_dtack_n_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ma_nxt      = r_ma;
    w_ras_n_nxt   = r_ras_n;
    w_casu_n_nxt  = r_casu_n;
    w_casl_n_nxt  = r_casl_n;
    w_we_n_nxt    = r_we_n;
    w_dtack_n_nxt = r_dtack_n;
    w_ref_clear   = 1'b0;
    w_to_pre      = 1'b0;
    w_idle_decide = 1'b0;

    case (r_state)
      S_IDLE: w_idle_decide = 1'b1;

      S_ROW: begin
        if (w_s_as_n) begin
          w_to_pre = 1'b1;
        end else begin
          w_ras_n_nxt = 1'b0;
          w_cnt_nxt   = c_LD_RCD;
          w_state_nxt = S_RAS;
        end
      end

      S_RAS: begin
        if (w_s_as_n) begin
          w_to_pre = 1'b1;
        end else if (r_cnt == '0) begin
          w_ma_nxt    = i_addr[2*MA_W-1:MA_W];
          w_we_n_nxt  = w_s_rw;
          w_state_nxt = S_COL;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      S_COL: begin
        if (w_s_as_n) begin
          w_to_pre = 1'b1;
        end else begin
          w_casu_n_nxt = w_s_uds_n;
          w_casl_n_nxt = w_s_lds_n;
          w_cnt_nxt    = c_LD_CAS;
          w_state_nxt  = S_CAS;
        end
      end

      S_CAS: begin
        if (w_s_as_n) begin
          w_to_pre = 1'b1;
        end else if (r_cnt == '0) begin
          w_dtack_n_nxt = 1'b0;
          w_state_nxt   = S_ACK;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      S_ACK: if (w_s_as_n) w_to_pre = 1'b1;

      // CAS stays low while RAS falls so the DRAM sees CAS-before-RAS.
      S_REF_CAS: begin
        w_ras_n_nxt = 1'b0;
        w_cnt_nxt   = c_LD_REF;
        w_state_nxt = S_REF_RAS;
      end

      S_REF_RAS: begin
        if (r_cnt == '0)
          w_to_pre = 1'b1;
        else
          w_cnt_nxt = r_cnt - 1'b1;
      end

      // The last precharge cycle doubles as the idle decision so the next
      // cycle can start straight after T_RP strobe-high cycles.
      S_PRECHARGE: begin
        if (r_cnt == '0)
          w_idle_decide = 1'b1;
        else
          w_cnt_nxt = r_cnt - 1'b1;
      end

      default: w_state_nxt = S_IDLE;
    endcase

    if (w_to_pre) begin
      w_ras_n_nxt   = 1'b1;
      w_casu_n_nxt  = 1'b1;
      w_casl_n_nxt  = 1'b1;
      w_we_n_nxt    = 1'b1;
      w_dtack_n_nxt = 1'b1;
      w_cnt_nxt     = c_LD_RP;
      w_state_nxt   = S_PRECHARGE;
    end

    // Refresh wins over a request seen in the same cycle.
    if (w_idle_decide) begin
      w_state_nxt = S_IDLE;
      if (w_ref_pending) begin
        w_casu_n_nxt = 1'b0;
        w_casl_n_nxt = 1'b0;
        w_we_n_nxt   = 1'b1;
        w_ref_clear  = 1'b1;
        w_state_nxt  = S_REF_CAS;
      end else if (w_req) begin
        w_ma_nxt    = i_addr[MA_W-1:0];
        w_state_nxt = S_ROW;
      end
    end
  end

  assign o_ma           = r_ma;
  assign o_ras_n        = r_ras_n;
  assign o_casu_n       = r_casu_n;
  assign o_casl_n       = r_casl_n;
  assign o_we_n         = r_we_n;
  assign o_dtack_dram_n = r_dtack_n;

`ifdef DRAM_REFCNT_EN
  logic [15:0] r_ref_count;

  always_ff @(posedge clk) begin
    if (rst)
      r_ref_count <= '0;
    else if (r_state == S_REF_RAS && r_cnt == '0)
      r_ref_count <= r_ref_count + 16'd1;
  end

  assign o_ref_count = r_ref_count;
`endif

endmodule : dram_controller
`default_nettype wire

// File: tb/tb_dram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_controller
//  Description : Self-checking bench. dut uses default timing for access,
//                abort, reset and refresh-collision sequences; dut_ref uses
//                REFRESH_CYCLES=16 with an idle bus for refresh spacing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dram_n = 1'b1, as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic [21:0] addr = '0;
  logic [10:0] ma;
  logic        ras_n, casu_n, casl_n, we_n, dtack_n;

  logic        tie_hi = 1'b1;
  logic [21:0] tie_addr = '0;
  logic [10:0] ma2;
  logic        ras2, casu2, casl2, we2, dtack2;
`ifdef DRAM_REFCNT_EN
  logic [15:0] refcnt, refcnt2;
`endif

  always #5 clk = ~clk;

  dram_controller dut (
    .clk(clk), .rst(rst), .i_dram_n(dram_n), .i_as_n(as_n), .i_uds_n(uds_n),
    .i_lds_n(lds_n), .i_rw(rw), .i_addr(addr), .o_ma(ma), .o_ras_n(ras_n),
    .o_casu_n(casu_n), .o_casl_n(casl_n), .o_we_n(we_n), .o_dtack_dram_n(dtack_n)
`ifdef DRAM_REFCNT_EN
    , .o_ref_count(refcnt)
`endif
  );

  dram_controller #(.REFRESH_CYCLES(16)) dut_ref (
    .clk(clk), .rst(rst), .i_dram_n(tie_hi), .i_as_n(tie_hi), .i_uds_n(tie_hi),
    .i_lds_n(tie_hi), .i_rw(tie_hi), .i_addr(tie_addr), .o_ma(ma2), .o_ras_n(ras2),
    .o_casu_n(casu2), .o_casl_n(casl2), .o_we_n(we2), .o_dtack_dram_n(dtack2)
`ifdef DRAM_REFCNT_EN
    , .o_ref_count(refcnt2)
`endif
  );

  typedef struct {
    logic [21:0] addr;
    logic        uds_n, lds_n, rw;
    logic [10:0] row, col;
    logic        casu, casl, we;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // {ras, casu, casl, we, dtack}
  function automatic logic [31:0] strobes();
    return {27'd0, ras_n, casu_n, casl_n, we_n, dtack_n};
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(vec_t v);
    addr = v.addr; uds_n = v.uds_n; lds_n = v.lds_n; rw = v.rw;
    dram_n = 1'b0; as_n = 1'b0;
  endtask

  task automatic release_bus();
    dram_n = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
  endtask

  task automatic do_access(int i, vec_t v);
    drive(v);
    tick(3);  // edge N: two synchroniser stages, then IDLE sees req
    chk($sformatf("v%0d_N_ma", i), ma, v.row);
    chk($sformatf("v%0d_N_str", i), strobes(), 5'b11111);
    tick(1);
    chk($sformatf("v%0d_N1_str", i), strobes(), 5'b01111);
    chk($sformatf("v%0d_N1_ma", i), ma, v.row);
    tick(1);
    chk($sformatf("v%0d_N2_ma", i), ma, v.col);
    chk($sformatf("v%0d_N2_str", i), strobes(), {1'b0, 1'b1, 1'b1, v.we, 1'b1});
    tick(1);
    chk($sformatf("v%0d_N3_str", i), strobes(), {1'b0, v.casu, v.casl, v.we, 1'b1});
    tick(1);
    chk($sformatf("v%0d_N4_str", i), strobes(), {1'b0, v.casu, v.casl, v.we, 1'b1});
    tick(1);
    chk($sformatf("v%0d_N5_str", i), strobes(), {1'b0, v.casu, v.casl, v.we, 1'b0});
    release_bus();
    tick(2);
    chk($sformatf("v%0d_hold_str", i), strobes(), {1'b0, v.casu, v.casl, v.we, 1'b0});
    tick(1);
    chk($sformatf("v%0d_end_str", i), strobes(), 5'b11111);
    tick(2);  // precharge
  endtask

  vec_t vecs[4];
  int   ev[$];
  logic prev_casl;

  initial begin
    vecs[0] = '{22'h2AB5AB, 1'b0, 1'b0, 1'b1, 11'h5AB, 11'h556, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{{11'h123, 11'h456}, 1'b1, 1'b0, 1'b0, 11'h456, 11'h123, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{{11'h7FF, 11'h000}, 1'b0, 1'b1, 1'b1, 11'h000, 11'h7FF, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{{11'h001, 11'h7FE}, 1'b0, 1'b0, 1'b0, 11'h7FE, 11'h001, 1'b0, 1'b0, 1'b0};

    // ---- reset state ----
    tick(3);
    chk("rst_str", strobes(), 5'b11111);
    chk("rst_ma", ma, 11'h000);
`ifdef DRAM_REFCNT_EN
    chk("rst_refcnt", refcnt2, 16'd0);
`endif
    rst = 1'b0;

    // ---- refresh spacing on the 16-cycle instance ----
    prev_casl = casl2;
    for (int k = 1; k <= 170; k++) begin
      tick(1);
      if (prev_casl === 1'b1 && casl2 === 1'b0) ev.push_back(k);
      prev_casl = casl2;
    end
    chk("ref_num", ev.size(), 10);
    if (ev.size() > 0) chk("ref_first", ev[0], 17);
    for (int i = 1; i < ev.size(); i++)
      chk($sformatf("ref_gap%0d", i), ev[i] - ev[i-1], 16);
`ifdef DRAM_REFCNT_EN
    chk("ref_count", refcnt2, 16'd10);
`endif

    // ---- access vectors ----
    for (int i = 0; i < 4; i++) do_access(i, vecs[i]);

    // ---- abort: synchronised AS_n high at N+2 ----
    drive(vecs[1]);
    tick(2);
    release_bus();
    tick(1);
    chk("abort_N_ma", ma, 11'h456);
    chk("abort_N_str", strobes(), 5'b11111);
    tick(1);
    chk("abort_N1_str", strobes(), 5'b01111);
    tick(1);
    chk("abort_N2_str", strobes(), 5'b11111);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk($sformatf("abort_quiet%0d", k), strobes(), 5'b11111);
    end

    // ---- reset while in CAS ----
    drive(vecs[0]);
    tick(6);  // N+3: CAS state
    chk("rcas_pre_str", strobes(), 5'b00011);
    rst = 1'b1;
    tick(1);
    chk("rcas_str", strobes(), 5'b11111);
    chk("rcas_ma", ma, 11'h000);
    release_bus();
    rst = 1'b0;

    // ---- collision: wrap and first visible req on the same edge ----
    tick(778);
    drive(vecs[0]);
    tick(3);
    chk("col_refcas_str", strobes(), 5'b10011);
    tick(1);
    chk("col_refras", ras_n, 1'b0);
    tick(3);
    chk("col_refend_str", strobes(), 5'b11111);
    tick(2);
    chk("col_N6_ma", ma, 11'h5AB);
    chk("col_N6_ras", ras_n, 1'b1);
    tick(1);
    chk("col_N7_ras", ras_n, 1'b0);
    tick(3);
    chk("col_N10_dtack", dtack_n, 1'b1);
    tick(1);
    chk("col_N11_dtack", dtack_n, 1'b0);
    release_bus();
    tick(3);
    chk("col_end_str", strobes(), 5'b11111);
`ifdef DRAM_REFCNT_EN
    chk("col_refcnt", refcnt, 16'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dram_controller
`default_nettype wire
